dcache_req_arbiter: RTL and testbench
=====================================

# dcache_req_arbiter

Serializes the two per-bundle data-memory requests of the dual-issue pipeline (slot 01 = older instruction, slot 02 = younger) onto the single request port of the data cache. Routes each cache response back to the issuing slot as `data_cache_data_ok_01/02` and `data_cache_rdata_01/02`, the signals consumed by `mem_stage`. Keeps program order and tracks outstanding transactions in a tag FIFO. Drops responses belonging to flushed instructions.

## Interface
- `OUTSTANDING`, 4: maximum accepted-but-unanswered cache transactions (power of two, ≥2).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush (exception/eret); marks all outstanding entries as discard.
- `req_01` / `req_02`  in  1  slot request; held high until the matching `addr_ok`.
- `wr_0x`  in  1  write.
- `size_0x`  in  2  0=byte, 1=half, 2=word.
- `wstrb_0x`  in  4  byte strobes.
- `addr_0x`  in  32  address.
- `wdata_0x`  in  32  store data.
- `addr_ok_01` / `addr_ok_02`  out  1  request accepted this cycle.
- `data_cache_data_ok_01` / `_02`  out  1  response for slot.
- `data_cache_rdata_01` / `_02`  out  32  load data.
- `dc_req`, `dc_wr`, `dc_size[1:0]`, `dc_wstrb[3:0]`, `dc_addr[31:0]`, `dc_wdata[31:0]`  out  cache request port.
- `dc_addr_ok`  in  1  cache accepted request.
- `dc_data_ok`  in  1  cache response (in order).
- `dc_rdata`  in  32  cache read data.

## Operation
- Grant: slot 01 has fixed priority; slot 02 is granted only when `req_01`=0. Upstream holds `req_02` while `req_01` is pending, so order is preserved.
- `dc_req = (req_01|req_02) & ~full & ~flush`. The `dc_*` payload muxes from the granted slot.
- `addr_ok_0x = dc_req & dc_addr_ok & grant_0x`.
- Tag FIFO, depth `OUTSTANDING`. Entry = {slot id, discard bit}.
  - Push on `dc_req & dc_addr_ok`.
  - Pop on `dc_data_ok`.
  - Stores get an entry too; the cache returns `data_ok` for writes.
- Response routing: on pop, if discard=0, `data_cache_data_ok_<slot>`=1 and `data_cache_rdata_<slot>=dc_rdata`. If discard=1, the response is silently consumed.
- Flush: sets the discard bit of every valid entry, including an entry being pushed the same cycle (unreachable anyway, since `dc_req` is masked). The entry popped in the flush cycle is also discarded.
- Full (count==`OUTSTANDING`): `dc_req`=0 even if a pop happens the same cycle. Grant resumes the next cycle.
- Empty with `dc_data_ok`=1: protocol error. Ignore it; count stays 0 and nothing is routed.
- Simultaneous push and pop (not full): count is unchanged and pointers both advance.
- Inactive response outputs drive rdata = 0.

## Timing
- Reset: count=0, pointers=0, all outputs 0 (including `dc_req`, `addr_ok_0x`, `data_ok_0x`).
- Request path is combinational: `req_0x` → `dc_req` in the same cycle, `dc_addr_ok` → `addr_ok_0x` in the same cycle.
- Response latency, no macro: 0 cycles; `dc_data_ok` → `data_cache_data_ok_0x` combinationally.
- Back-to-back pair: slot 01 is accepted in cycle N and slot 02 in cycle N+1 at the earliest.
- Reset asserted mid-transaction clears the FIFO. Any cache responses arriving later are treated as the empty-pop case.

## Configuration
- `DCACHE_ARB_RESP_REG_EN` defined: response outputs (`data_ok_0x`, `rdata_0x`) are registered, giving 1 cycle of added latency and cutting the cache → `mem_stage` combinational path. Registered outputs reset to 0. A flush does not cancel a response already registered.
- Undefined: combinational routing as above.

## Structure
- Shared header `mycpu.h`: size encodings (`DC_SIZE_B/H/W`), tag entry width, request bus width macro.
- Sub-module `arb_tag_fifo`: parameterised circular FIFO with push/pop, full/empty/count, and a broadcast-set-discard input.
- The top holds the grant mux, the request gating, and response routing/register.

## Test plan
- Single load on slot 01, addr 0x1000, `dc_addr_ok` immediate, `dc_data_ok` 3 cycles later with rdata 0xDEADBEEF → `addr_ok_01` in cycle 0; `data_ok_01`=1 with 0xDEADBEEF in cycle 3 (cycle 4 with macro); `data_ok_02` stays 0.
- Pair load (01 @0x10, 02 @0x14) raised together → `dc_addr` = 0x10 then 0x14 on consecutive cycles. Responses 0xA, 0xB route to slot 01 then slot 02 respectively.
- 4 outstanding loads with no responses (`OUTSTANDING`=4) → fifth request sees `dc_req`=0. The cycle after the first `dc_data_ok`, `dc_req`=1 again.
- 2 outstanding loads, `flush` pulsed, then 2 responses → no `data_ok_0x` asserted; count returns to 0; the next request proceeds normally.
- Store on slot 02 (wstrb 0b0011) with slot 01 idle → `dc_wr`=1, `dc_wstrb`=0011; `dc_data_ok` yields `data_ok_02`=1.
- Spurious `dc_data_ok` while empty → no output asserted, count stays 0.

Source files
------------

// File: rtl/dcache_req_arbiter_pkg.sv
// dcache_req_arbiter_pkg: size encodings, tag FIFO entry type, request bus width shared by the arbiter and its tag FIFO
package dcache_req_arbiter_pkg;
  localparam logic [1:0] DC_SIZE_B = 2'd0;
  localparam logic [1:0] DC_SIZE_H = 2'd1;
  localparam logic [1:0] DC_SIZE_W = 2'd2;
  typedef enum logic {SLOT_01 = 1'b0, SLOT_02 = 1'b1} slot_e;
  typedef struct packed {
    slot_e slot;
    logic  discard;
  } tag_t;
  localparam int TAG_W = $bits(tag_t);
  localparam int REQ_W = 1 + 2 + 4 + 32 + 32;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: circular FIFO of tag_t (clk, reset, push, pop, set_discard broadcast, din -> head, count, full)
module arb_tag_fifo
  import dcache_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     set_discard,
  input  tag_t                     din,
  output tag_t                     head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  tag_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign do_push = push & ~full;
  assign do_pop = pop & (count != '0);
  assign head = mem[rp];
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && wp == AW'(i)) mem[i] <= '{slot: din.slot, discard: din.discard | set_discard};
      else if (set_discard) mem[i].discard <= 1'b1;
    end
  end
endmodule

// File: rtl/dcache_req_arbiter.sv
// dcache_req_arbiter: serializes slot 01/02 requests onto dc_* port, routes in-order dc responses back per slot, drops flushed ones; DCACHE_ARB_RESP_REG_EN registers the response outputs
module dcache_req_arbiter
  import dcache_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_01,
  input  logic        wr_01,
  input  logic [1:0]  size_01,
  input  logic [3:0]  wstrb_01,
  input  logic [31:0] addr_01,
  input  logic [31:0] wdata_01,
  input  logic        req_02,
  input  logic        wr_02,
  input  logic [1:0]  size_02,
  input  logic [3:0]  wstrb_02,
  input  logic [31:0] addr_02,
  input  logic [31:0] wdata_02,
  output logic        addr_ok_01,
  output logic        addr_ok_02,
  output logic        data_cache_data_ok_01,
  output logic        data_cache_data_ok_02,
  output logic [31:0] data_cache_rdata_01,
  output logic [31:0] data_cache_rdata_02,
  output logic        dc_req,
  output logic        dc_wr,
  output logic [1:0]  dc_size,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_addr,
  output logic [31:0] dc_wdata,
  input  logic        dc_addr_ok,
  input  logic        dc_data_ok,
  input  logic [31:0] dc_rdata
);
  logic full, hit, hit_01, hit_02;
  logic [$clog2(OUTSTANDING):0] count;
  logic [REQ_W-1:0] req_bus;
  tag_t head;
  assign req_bus = req_01 ? {wr_01, size_01, wstrb_01, addr_01, wdata_01}
                          : {wr_02, size_02, wstrb_02, addr_02, wdata_02};
  assign {dc_wr, dc_size, dc_wstrb, dc_addr, dc_wdata} = req_bus;
  assign dc_req = (req_01 | req_02) & ~full & ~flush & ~reset;
  assign addr_ok_01 = dc_req & dc_addr_ok & req_01;
  assign addr_ok_02 = dc_req & dc_addr_ok & ~req_01;
  assign hit = dc_data_ok & (count != '0) & ~head.discard & ~flush & ~reset;
  assign hit_01 = hit & (head.slot == SLOT_01);
  assign hit_02 = hit & (head.slot == SLOT_02);
  arb_tag_fifo #(.DEPTH(OUTSTANDING)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(dc_req & dc_addr_ok),
    .pop(dc_data_ok),
    .set_discard(flush),
    .din('{slot: req_01 ? SLOT_01 : SLOT_02, discard: 1'b0}),
    .head(head),
    .count(count),
    .full(full)
  );
`ifdef DCACHE_ARB_RESP_REG_EN
  always_ff @(posedge clk) begin
    data_cache_data_ok_01 <= ~reset & hit_01;
    data_cache_data_ok_02 <= ~reset & hit_02;
    data_cache_rdata_01 <= (~reset & hit_01) ? dc_rdata : '0;
    data_cache_rdata_02 <= (~reset & hit_02) ? dc_rdata : '0;
  end
`else
  assign data_cache_data_ok_01 = hit_01;
  assign data_cache_data_ok_02 = hit_02;
  assign data_cache_rdata_01 = hit_01 ? dc_rdata : '0;
  assign data_cache_rdata_02 = hit_02 ? dc_rdata : '0;
`endif
endmodule

// File: tb/tb_dcache_req_arbiter.sv
// tb_dcache_req_arbiter: directed self-checking bench for dcache_req_arbiter (default build, combinational responses)
module tb_dcache_req_arbiter;
  import dcache_req_arbiter_pkg::*;
  logic clk = 0, reset, flush;
  logic req_01, wr_01, req_02, wr_02;
  logic [1:0] size_01, size_02, dc_size;
  logic [3:0] wstrb_01, wstrb_02, dc_wstrb;
  logic [31:0] addr_01, wdata_01, addr_02, wdata_02;
  logic addr_ok_01, addr_ok_02, ok_01, ok_02;
  logic [31:0] rd_01, rd_02;
  logic dc_req, dc_wr, dc_addr_ok, dc_data_ok;
  logic [31:0] dc_addr, dc_wdata, dc_rdata;
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  dcache_req_arbiter #(.OUTSTANDING(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_01(req_01), .wr_01(wr_01), .size_01(size_01), .wstrb_01(wstrb_01), .addr_01(addr_01), .wdata_01(wdata_01),
    .req_02(req_02), .wr_02(wr_02), .size_02(size_02), .wstrb_02(wstrb_02), .addr_02(addr_02), .wdata_02(wdata_02),
    .addr_ok_01(addr_ok_01), .addr_ok_02(addr_ok_02),
    .data_cache_data_ok_01(ok_01), .data_cache_data_ok_02(ok_02),
    .data_cache_rdata_01(rd_01), .data_cache_rdata_02(rd_02),
    .dc_req(dc_req), .dc_wr(dc_wr), .dc_size(dc_size), .dc_wstrb(dc_wstrb), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_addr_ok(dc_addr_ok), .dc_data_ok(dc_data_ok), .dc_rdata(dc_rdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  initial begin
    reset = 1; flush = 0;
    req_01 = 0; wr_01 = 0; size_01 = DC_SIZE_W; wstrb_01 = 0; addr_01 = 0; wdata_01 = 0;
    req_02 = 0; wr_02 = 0; size_02 = DC_SIZE_B; wstrb_02 = 0; addr_02 = 0; wdata_02 = 0;
    dc_addr_ok = 0; dc_data_ok = 0; dc_rdata = 0;
    tick;
    mid;
    chk("rst_dc_req", dc_req, 0);
    chk("rst_addr_ok", {addr_ok_01, addr_ok_02}, 0);
    chk("rst_data_ok", {ok_01, ok_02}, 0);
    chk("rst_rdata", rd_01 | rd_02, 0);
    chk("rst_count", dut.count, 0);
    tick;
    reset = 0;
    req_01 = 1; addr_01 = 32'h1000; dc_addr_ok = 1;
    mid;
    chk("t1_dc_req", dc_req, 1);
    chk("t1_dc_addr", dc_addr, 32'h1000);
    chk("t1_addr_ok_01", addr_ok_01, 1);
    chk("t1_addr_ok_02", addr_ok_02, 0);
    tick;
    req_01 = 0; dc_addr_ok = 0;
    mid;
    chk("t1_wait1", ok_01, 0);
    tick;
    mid;
    chk("t1_wait2", ok_01, 0);
    tick;
    dc_data_ok = 1; dc_rdata = 32'hDEADBEEF;
    mid;
    chk("t1_ok_01", ok_01, 1);
    chk("t1_rd_01", rd_01, 32'hDEADBEEF);
    chk("t1_ok_02", ok_02, 0);
    chk("t1_rd_02", rd_02, 0);
    tick;
    dc_data_ok = 0;
    mid;
    chk("t1_count", dut.count, 0);
    tick;
    req_01 = 1; addr_01 = 32'h10; req_02 = 1; addr_02 = 32'h14; dc_addr_ok = 1;
    mid;
    chk("t2_addr_a", dc_addr, 32'h10);
    chk("t2_ok01_a", addr_ok_01, 1);
    chk("t2_ok02_a", addr_ok_02, 0);
    tick;
    req_01 = 0;
    mid;
    chk("t2_addr_b", dc_addr, 32'h14);
    chk("t2_ok02_b", addr_ok_02, 1);
    tick;
    req_02 = 0; dc_addr_ok = 0;
    mid;
    chk("t2_count", dut.count, 2);
    tick;
    dc_data_ok = 1; dc_rdata = 32'hA;
    mid;
    chk("t2_resp_a", {ok_01, ok_02}, 2'b10);
    chk("t2_rd_a", rd_01, 32'hA);
    tick;
    dc_rdata = 32'hB;
    mid;
    chk("t2_resp_b", {ok_01, ok_02}, 2'b01);
    chk("t2_rd_b", rd_02, 32'hB);
    chk("t2_rd_b_other", rd_01, 0);
    tick;
    dc_data_ok = 0;
    req_01 = 1; addr_01 = 32'h100; dc_addr_ok = 1;
    for (int k = 0; k < 4; k++) begin
      mid;
      chk("t3_fill_dc_req", dc_req, 1);
      tick;
    end
    mid;
    chk("t3_full_dc_req", dc_req, 0);
    chk("t3_full_addr_ok", addr_ok_01, 0);
    chk("t3_full_count", dut.count, 4);
    tick;
    dc_data_ok = 1; dc_rdata = 32'h1;
    mid;
    chk("t3_pop_dc_req", dc_req, 0);
    chk("t3_pop_ok_01", ok_01, 1);
    tick;
    dc_data_ok = 0;
    mid;
    chk("t3_resume_dc_req", dc_req, 1);
    chk("t3_resume_addr_ok", addr_ok_01, 1);
    chk("t3_resume_count", dut.count, 3);
    tick;
    req_01 = 0; dc_addr_ok = 0;
    mid;
    chk("t3_refill_count", dut.count, 4);
    tick;
    dc_data_ok = 1;
    for (int k = 0; k < 4; k++) begin
      dc_rdata = 32'h20 + k;
      mid;
      chk("t3_drain_ok_01", ok_01, 1);
      chk("t3_drain_rd_01", rd_01, 32'h20 + k);
      tick;
    end
    dc_data_ok = 0;
    mid;
    chk("t3_drain_count", dut.count, 0);
    tick;
    req_01 = 1; addr_01 = 32'h200; dc_addr_ok = 1;
    mid;
    tick;
    mid;
    tick;
    flush = 1;
    mid;
    chk("t4_flush_dc_req", dc_req, 0);
    chk("t4_flush_addr_ok", addr_ok_01, 0);
    chk("t4_flush_count", dut.count, 2);
    tick;
    flush = 0; req_01 = 0; dc_addr_ok = 0; dc_data_ok = 1; dc_rdata = 32'h77;
    for (int k = 0; k < 2; k++) begin
      mid;
      chk("t4_drop_ok", {ok_01, ok_02}, 0);
      chk("t4_drop_rd", rd_01 | rd_02, 0);
      tick;
    end
    dc_data_ok = 0;
    mid;
    chk("t4_count", dut.count, 0);
    tick;
    req_02 = 1; wr_02 = 1; size_02 = DC_SIZE_H; wstrb_02 = 4'b0011; addr_02 = 32'h40; wdata_02 = 32'h1234; dc_addr_ok = 1;
    mid;
    chk("t5_dc_req", dc_req, 1);
    chk("t5_dc_wr", dc_wr, 1);
    chk("t5_dc_wstrb", dc_wstrb, 4'b0011);
    chk("t5_dc_size", dc_size, DC_SIZE_H);
    chk("t5_dc_wdata", dc_wdata, 32'h1234);
    chk("t5_addr_ok", {addr_ok_01, addr_ok_02}, 2'b01);
    tick;
    req_02 = 0; wr_02 = 0; dc_addr_ok = 0; dc_data_ok = 1; dc_rdata = 0;
    mid;
    chk("t5_ok", {ok_01, ok_02}, 2'b01);
    tick;
    dc_data_ok = 0;
    req_01 = 1; addr_01 = 32'h300; dc_addr_ok = 1;
    mid;
    tick;
    req_01 = 0; dc_addr_ok = 0; dc_data_ok = 1; dc_rdata = 32'h99; flush = 1;
    mid;
    chk("t6_flushpop_ok", {ok_01, ok_02}, 0);
    chk("t6_flushpop_rd", rd_01, 0);
    tick;
    dc_data_ok = 0; flush = 0;
    mid;
    chk("t6_count", dut.count, 0);
    tick;
    dc_data_ok = 1; dc_rdata = 32'h55;
    mid;
    chk("t7_spur_ok", {ok_01, ok_02}, 0);
    chk("t7_spur_rd", rd_01 | rd_02, 0);
    tick;
    dc_data_ok = 0;
    mid;
    chk("t7_count", dut.count, 0);
    chk("t7_dc_req", dc_req, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
